// File: rtl/softmax_norm.sv
// softmax_norm: buffers one row of partial exponentials (16 lanes per beat),
// then, once the final running max and denominator arrive, rescales every
// stored beat to the final max and divides by the denominator, streaming
// Q0.8 probabilities out under a valid/ready handshake.
`timescale 1ns/1ps
module softmax_norm #(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [127:0] i_y,
    input  logic [479:0] i_runmax,
    input  logic         i_y_valid,
    input  logic [143:0] i_denom,
    input  logic         i_denom_valid,
    input  logic         i_ready,
    output logic [127:0] o_prob,
    output logic         o_valid,
    output logic         o_last,
    output logic         o_busy,
    output logic         o_err
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wr_cnt_reg, wr_cnt_next;
    logic [CW-1:0]   rd_cnt_reg, rd_cnt_next;
    logic [CW-1:0]   len_reg, len_next;
    logic [479:0]    fmax_reg, fmax_next;
    logic [143:0]    fden_reg, fden_next;
    logic [127:0]    prob_reg, prob_next;
    logic            valid_reg, valid_next;
    logic            last_reg, last_next;
    logic            err_reg, err_next;

    // Row buffer: y and the running max that was in effect for each beat
    logic [127:0]    mem_y  [N];
    logic [479:0]    mem_rm [N];
    logic            mem_we;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;

    logic            full;
    logic [CW-1:0]   rd_plus1;

    // Operands of the normalizer: the beat being prepared and its row constants
    logic [127:0]    sel_y;
    logic [479:0]    sel_rm;
    logic [479:0]    sel_max;
    logic [143:0]    sel_den;
    logic [127:0]    lane_prob;

    assign full     = (wr_cnt_reg == CW'(N));
    assign wr_addr  = wr_cnt_reg[AW-1:0];
    assign rd_plus1 = rd_cnt_reg + CW'(1);

    // Next read address: entry 0 while filling, else the beat after the one on the output
    always_comb begin
        rd_addr = '0;
        if (state_reg == S_DRAIN && rd_plus1 < CW'(N)) begin
            rd_addr = rd_plus1[AW-1:0];
        end
    end

    // Operand select; the read is combinational so beat 0 can be registered on the denom edge
    always_comb begin
        sel_y   = mem_y[rd_addr];
        sel_rm  = mem_rm[rd_addr];
        sel_max = fmax_reg;
        sel_den = fden_reg;
        if (state_reg == S_FILL) begin
            sel_max = i_runmax;
            sel_den = i_denom;
            if (wr_cnt_reg == '0) begin
                sel_y  = i_y;
                sel_rm = i_runmax;
            end
        end
    end

    // Per-lane rescale to the final max, divide by the denominator, saturate to 8 bits
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        logic signed [29:0] d;
        logic [7:0]         y;
        logic [7:0]         c;
        logic [8:0]         den;
        logic [16:0]        q;
        logic [7:0]         p;

        assign y   = sel_y[8*gi +: 8];
        assign den = sel_den[9*gi +: 9];

        // Shift-based rescale, then quotient with zero-denominator guard and clamp
        always_comb begin
            d = signed'(sel_max[30*gi +: 30]) - signed'(sel_rm[30*gi +: 30]);
            if (d >= 30'sd8) begin
                c = 8'd0;
            end else if (d <= 30'sd0) begin
                c = y;
            end else begin
                c = y >> d[2:0];
            end
            if (den == 9'd0) begin
                q = 17'd0;
            end else begin
                q = {1'b0, c, 8'd0} / {8'd0, den};
            end
            p = (q > 17'd255) ? 8'hFF : q[7:0];
        end

        assign lane_prob[8*gi +: 8] = p;
    end

    // Next-state and datapath control for the fill / drain sequence
    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        rd_cnt_next = rd_cnt_reg;
        len_next    = len_reg;
        fmax_next   = fmax_reg;
        fden_next   = fden_reg;
        prob_next   = prob_reg;
        valid_next  = valid_reg;
        last_next   = last_reg;
        err_next    = err_reg;
        mem_we      = 1'b0;

        case (state_reg)
            S_FILL: begin
                if (i_y_valid) begin
                    if (!full) begin
                        mem_we      = 1'b1;
                        wr_cnt_next = wr_cnt_reg + CW'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                    if (i_denom_valid) begin
                        // A closing beat on a full buffer is dropped; the row keeps N beats
                        len_next    = full ? CW'(N) : (wr_cnt_reg + CW'(1));
                        fden_next   = i_denom;
                        fmax_next   = i_runmax;
                        wr_cnt_next = '0;
                        rd_cnt_next = '0;
                        prob_next   = lane_prob;
                        valid_next  = 1'b1;
                        last_next   = (len_next == CW'(1));
                        state_next  = S_DRAIN;
                    end
                end else if (i_denom_valid) begin
                    err_next = 1'b1;
                end
            end
            S_DRAIN: begin
                if (i_y_valid || i_denom_valid) begin
                    err_next = 1'b1;
                end
                if (valid_reg && i_ready) begin
                    if (last_reg) begin
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        state_next = S_FILL;
                    end else begin
                        rd_cnt_next = rd_plus1;
                        prob_next   = lane_prob;
                        last_next   = (rd_plus1 == len_reg - CW'(1));
                    end
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    // State and control registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= S_FILL;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
            len_reg    <= '0;
            fmax_reg   <= '0;
            fden_reg   <= '0;
            prob_reg   <= '0;
            valid_reg  <= 1'b0;
            last_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_cnt_reg <= wr_cnt_next;
            rd_cnt_reg <= rd_cnt_next;
            len_reg    <= len_next;
            fmax_reg   <= fmax_next;
            fden_reg   <= fden_next;
            prob_reg   <= prob_next;
            valid_reg  <= valid_next;
            last_reg   <= last_next;
            err_reg    <= err_next;
        end
    end

    // Buffer write; contents survive reset since the counters make them unreachable
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_y[wr_addr]  <= i_y;
            mem_rm[wr_addr] <= i_runmax;
        end
    end

    assign o_prob  = prob_reg;
    assign o_valid = valid_reg;
    assign o_last  = last_reg;
    assign o_busy  = (state_reg == S_DRAIN);
    assign o_err   = err_reg;

endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: table-driven and randomized checks of softmax_norm against
// a plain-arithmetic reference of the rescale/divide/saturate rules.
`timescale 1ns/1ps
module tb_softmax_norm;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] y;
    logic [479:0] runmax;
    logic         y_valid;
    logic [143:0] denom;
    logic         denom_valid;
    logic         ready;
    logic [127:0] prob;
    logic         valid;
    logic         last;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    softmax_norm #(.N(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_y          (y),
        .i_runmax     (runmax),
        .i_y_valid    (y_valid),
        .i_denom      (denom),
        .i_denom_valid(denom_valid),
        .i_ready      (ready),
        .o_prob       (prob),
        .o_valid      (valid),
        .o_last       (last),
        .o_busy       (busy),
        .o_err        (err)
    );

    int total = 0;
    int bad   = 0;

    // Current row stimulus and its expected output beats
    logic [127:0] ry  [16];
    logic [479:0] rrm [16];
    logic [143:0] rden;
    logic [127:0] exq [$];

    typedef struct {
        logic [7:0]         y;
        logic signed [29:0] rm;
        logic signed [29:0] fmax;
        logic [8:0]         den;
        logic [7:0]         exp_p;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exp2-style rescale by shift, then floor(c*256/den), clamp to 255
    function automatic logic [7:0] ref_lane(input logic [7:0] yy, input logic signed [29:0] rm,
                                            input logic signed [29:0] mx, input logic [8:0] dn);
        logic signed [29:0] d;
        int c;
        int q;
        d = mx - rm;
        if (d >= 8)       c = 0;
        else if (d <= 0)  c = int'(yy);
        else              c = int'(yy) >> int'(d);
        if (dn == 9'd0)   q = 0;
        else              q = (c * 256) / int'(dn);
        return (q > 255) ? 8'd255 : 8'(q);
    endfunction

    task automatic build_expect(input int n);
        logic [127:0] v;
        exq.delete();
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < 16; l++) begin
                v[8*l +: 8] = ref_lane(ry[k][8*l +: 8], rrm[k][30*l +: 30],
                                       rrm[n-1][30*l +: 30], rden[9*l +: 9]);
            end
            exq.push_back(v);
        end
    endtask

    task automatic random_row(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < 16; l++) begin
                ry[k][8*l +: 8] = 8'($urandom_range(0, 255));
                t = int'($urandom_range(0, 40)) - 20;
                rrm[k][30*l +: 30] = 30'(t);
            end
        end
        for (int l = 0; l < 16; l++) begin
            rden[9*l +: 9] = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
        end
    endtask

    // Send n beats; the last one carries the denominator
    task automatic fill(input int n);
        for (int k = 0; k < n; k++) begin
            y           = ry[k];
            runmax      = rrm[k];
            y_valid     = 1'b1;
            denom_valid = (k == n - 1);
            denom       = rden;
            tick();
        end
        y_valid     = 1'b0;
        denom_valid = 1'b0;
    endtask

    // Collect up to 'stop' beats; mode 0 ready high, 1 pattern 1,0,0,1, 2 random
    task automatic drain(input int n, input int mode, input int inject_at, input int stop);
        int idx = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [127:0] held_prob = '0;
        logic held_last = 1'b0;
        logic r;
        check("first_valid", 128'(valid), 128'd1);
        check("busy_in_drain", 128'(busy), 128'd1);
        while (idx < stop && cyc < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            ready   = r;
            y_valid = (cyc == inject_at);
            if (cyc == inject_at) begin
                y      = 128'({$urandom, $urandom, $urandom, $urandom});
                runmax = '0;
            end
            check("valid_gap", 128'(valid), 128'd1);
            if (stalled) begin
                check("stall_prob", prob, held_prob);
                check("stall_last", 128'(last), 128'(held_last));
            end
            if (valid && r) begin
                $display("beat %0d/%0d prob=%h last=%0d", idx, n, prob, last);
                check("beat_prob", prob, exq[idx]);
                check("beat_last", 128'(last), 128'(idx == n - 1));
                idx++;
            end
            stalled   = valid && !r;
            held_prob = prob;
            held_last = last;
            tick();
            cyc++;
        end
        ready   = 1'b0;
        y_valid = 1'b0;
        if (idx < stop) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats expected %0d", idx, stop);
        end
        if (stop == n) begin
            check("valid_drop", 128'(valid), 128'd0);
            check("busy_drop", 128'(busy), 128'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_prob"},  prob, 128'd0);
        check({tag, "_valid"}, 128'(valid), 128'd0);
        check({tag, "_last"},  128'(last), 128'd0);
        check({tag, "_busy"},  128'(busy), 128'd0);
        check({tag, "_err"},   128'(err), 128'd0);
    endtask

    initial begin
        rst_n = 1'b0; y = '0; runmax = '0; y_valid = 1'b0;
        denom = '0; denom_valid = 1'b0; ready = 1'b0;

        tbl[0]  = '{8'd128, 30'sd0,  30'sd2,  9'd160, 8'd51};
        tbl[1]  = '{8'd128, 30'sd2,  30'sd2,  9'd160, 8'd204};
        tbl[2]  = '{8'd128, 30'sd0,  30'sd9,  9'd256, 8'd0};
        tbl[3]  = '{8'd128, 30'sd5,  30'sd5,  9'd128, 8'd255};
        tbl[4]  = '{8'd128, 30'sd5,  30'sd5,  9'd0,   8'd0};
        tbl[5]  = '{8'd200, 30'sd10, 30'sd3,  9'd256, 8'd200};
        tbl[6]  = '{8'd255, 30'sd0,  30'sd7,  9'd1,   8'd255};
        tbl[7]  = '{8'd255, 30'sd0,  30'sd8,  9'd1,   8'd0};
        tbl[8]  = '{8'd100, 30'sd0,  30'sd1,  9'd300, 8'd42};
        tbl[9]  = '{8'd1,   30'sd0,  30'sd0,  9'd511, 8'd0};
        tbl[10] = '{8'd64,  -30'sd5, -30'sd3, 9'd256, 8'd16};

        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single-case vectors as 2-beat rows; the second beat (y=0) fixes the final max
        for (int i = 0; i < 11; i++) begin
            ry[0]  = {16{tbl[i].y}};
            rrm[0] = {16{tbl[i].rm}};
            ry[1]  = '0;
            rrm[1] = {16{tbl[i].fmax}};
            rden   = {16{tbl[i].den}};
            exq.delete();
            exq.push_back({16{tbl[i].exp_p}});
            exq.push_back(128'd0);
            fill(2);
            drain(2, 0, -1, 2);
        end

        // Two-beat row with both beats live
        ry[0] = {16{8'd128}}; rrm[0] = {16{30'd0}};
        ry[1] = {16{8'd128}}; rrm[1] = {16{30'd2}};
        rden  = {16{9'd160}};
        exq.delete();
        exq.push_back({16{8'd51}});
        exq.push_back({16{8'd204}});
        fill(2);
        drain(2, 0, -1, 2);

        // Full 16-beat row, once with ready high and once with ready toggling
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                ry[k]  = {16{8'd128}};
                rrm[k] = {16{30'd5}};
            end
            rden = {16{9'd256}};
            exq.delete();
            for (int k = 0; k < 16; k++) exq.push_back({16{8'd128}});
            fill(16);
            drain(16, m, -1, 16);
        end
        check("err_clean", 128'(err), 128'd0);

        // Randomized rows against the reference model
        for (int r = 0; r < 20; r++) begin
            int n;
            n = int'($urandom_range(1, 16));
            random_row(n);
            build_expect(n);
            fill(n);
            drain(n, int'($urandom_range(0, 2)), -1, n);
        end
        check("err_clean_rand", 128'(err), 128'd0);

        // Beat pushed during drain: flagged, stream unaffected, flag sticky
        random_row(6);
        build_expect(6);
        fill(6);
        drain(6, 1, 1, 6);
        check("err_drain_beat", 128'(err), 128'd1);
        random_row(4);
        build_expect(4);
        fill(4);
        drain(4, 0, -1, 4);
        check("err_sticky", 128'(err), 128'd1);

        rst_n = 1'b0;
        tick();
        check("err_reset", 128'(err), 128'd0);
        rst_n = 1'b1;
        tick();

        // Seventeenth beat with no denominator overflows the buffer
        random_row(16);
        for (int k = 0; k < 16; k++) begin
            y = ry[k]; runmax = rrm[k]; y_valid = 1'b1; denom_valid = 1'b0;
            tick();
        end
        check("err_before_overflow", 128'(err), 128'd0);
        tick();
        y_valid = 1'b0;
        check("err_overflow", 128'(err), 128'd1);
        check("no_valid_overflow", 128'(valid), 128'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset asserted during drain beat 3 abandons the row
        random_row(8);
        build_expect(8);
        fill(8);
        drain(8, 0, -1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("no_valid_after_reset", 128'(valid), 128'd0);

        random_row(16);
        build_expect(16);
        fill(16);
        drain(16, 2, -1, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
